// File: rtl/mistral_dsp_pkg.sv
// Shared types and helpers for the Mistral DSP multiply-accumulate block.
// The optional saturating accumulator is selected with MISTRAL_DSP_ACC_SAT_EN.
package mistral_dsp_pkg;

  typedef enum logic [1:0] {
    MUL9  = 2'd0,
    MUL18 = 2'd1,
    MUL27 = 2'd2
  } mul_mode_e;

  localparam int MUL9_W        = 9;
  localparam int MUL18_W       = 18;
  localparam int MUL27_W       = 27;
  localparam int ACC_WIDTH_MAX = 64;

  // Control bits that travel alongside a sample through the pipeline.
  typedef struct packed {
    logic valid;
    logic load;
    logic acc;
  } mac_ctrl_t;

  // Smallest native multiplier that covers both operand widths.
  function automatic mul_mode_e sel_mode(input int a_w, input int b_w);
    int m;
    m = (a_w > b_w) ? a_w : b_w;
    if (m <= MUL9_W) begin
      return MUL9;
    end else if (m <= MUL18_W) begin
      return MUL18;
    end
    return MUL27;
  endfunction

  function automatic int mode_width(input mul_mode_e m);
    case (m)
      MUL9:    return MUL9_W;
      MUL18:   return MUL18_W;
      default: return MUL27_W;
    endcase
  endfunction

endpackage

// File: rtl/mistral_dsp_mac_if.sv
// Sample/result bus of mistral_dsp_mac; clock and reset stay outside.
// Built the same way whether or not MISTRAL_DSP_ACC_SAT_EN is defined.
interface mistral_dsp_mac_if #(
  parameter int A_WIDTH   = 27,
  parameter int B_WIDTH   = 27,
  parameter int ACC_WIDTH = 64
);

  // Valid-only stream, no backpressure: a sample (A, B, LOAD, ACC) is taken
  // when IN_VALID is high at a rising clock edge with ENA high. OUT_VALID marks
  // the cycle Y picks up a new result; ENA low freezes it with everything else.
  logic                 ENA;
  logic                 IN_VALID;
  logic [A_WIDTH-1:0]   A;
  logic [B_WIDTH-1:0]   B;
  logic                 LOAD;
  logic                 ACC;
  logic [ACC_WIDTH-1:0] Y;
  logic                 OUT_VALID;
  logic                 OVF;

  modport master (
    output ENA, IN_VALID, A, B, LOAD, ACC,
    input  Y, OUT_VALID, OVF
  );

  modport slave (
    input  ENA, IN_VALID, A, B, LOAD, ACC,
    output Y, OUT_VALID, OVF
  );

endinterface

// File: rtl/mistral_dsp_mul.sv
// Combinational extend-and-multiply sized to the selected native DSP mode.
// Independent of MISTRAL_DSP_ACC_SAT_EN.
module mistral_dsp_mul
  import mistral_dsp_pkg::*;
#(
  parameter int        A_WIDTH  = 27,
  parameter int        B_WIDTH  = 27,
  parameter bit        A_SIGNED = 1'b1,
  parameter bit        B_SIGNED = 1'b1,
  parameter mul_mode_e MODE     = MUL27,
  localparam int       MW       = mode_width(MODE),
  localparam int       PW       = 2 * MW
) (
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [B_WIDTH-1:0] b_i,
  output logic [PW-1:0]      p_o
);

  logic [MW-1:0]        a_m;
  logic [MW-1:0]        b_m;
  logic signed [MW:0]   a_s;
  logic signed [MW:0]   b_s;
  logic signed [PW-1:0] prod;

  // One guard bit lets a single signed multiplier serve every signedness mix;
  // the low PW bits of the product are exact for all of them.
  always_comb begin
    if (A_SIGNED) a_m = MW'($signed(a_i));
    else          a_m = MW'(a_i);
    if (B_SIGNED) b_m = MW'($signed(b_i));
    else          b_m = MW'(b_i);

    a_s  = {(A_SIGNED ? a_m[MW-1] : 1'b0), a_m};
    b_s  = {(B_SIGNED ? b_m[MW-1] : 1'b0), b_m};
    prod = PW'(a_s) * PW'(b_s);
    p_o  = prod;
  end

endmodule

// File: rtl/mistral_dsp_mac.sv
// Three-stage registered multiply-accumulate with sticky overflow flag.
// Define MISTRAL_DSP_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module mistral_dsp_mac
  import mistral_dsp_pkg::*;
#(
  parameter int A_WIDTH   = 27,
  parameter int B_WIDTH   = 27,
  parameter bit A_SIGNED  = 1'b1,
  parameter bit B_SIGNED  = 1'b1,
  parameter int ACC_WIDTH = 64
) (
  input  logic             CLK,
  input  logic             ACLR,
  mistral_dsp_mac_if.slave bus
);

  localparam mul_mode_e MODE     = sel_mode(A_WIDTH, B_WIDTH);
  localparam int        MW       = mode_width(MODE);
  localparam int        PW       = 2 * MW;
  localparam bit        P_SIGNED = A_SIGNED || B_SIGNED;
  localparam int        MSB      = ACC_WIDTH - 1;

  // Stage 1: operands and control
  logic [A_WIDTH-1:0]   a_q;
  logic [B_WIDTH-1:0]   b_q;
  mac_ctrl_t            ctrl1_q;
  mac_ctrl_t            ctrl1_d;

  // Stage 2: product and control
  logic [PW-1:0]        p_d;
  logic [PW-1:0]        p_q;
  mac_ctrl_t            ctrl2_q;

  // Stage 3: accumulator and flags
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_d;
  logic                 ovf_q;
  logic                 out_valid_q;

  logic signed [PW:0]   p_sx;
  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] add_res;
  logic                 add_ovf;

  always_comb begin
    ctrl1_d       = '0;
    ctrl1_d.valid = bus.IN_VALID;
    ctrl1_d.load  = bus.LOAD;
    ctrl1_d.acc   = bus.ACC;
  end

  always_ff @(posedge CLK or negedge ACLR) begin
    if (!ACLR) begin
      a_q     <= '0;
      b_q     <= '0;
      ctrl1_q <= '0;
    end else if (bus.ENA) begin
      a_q     <= bus.A;
      b_q     <= bus.B;
      ctrl1_q <= ctrl1_d;
    end
  end

  mistral_dsp_mul #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .A_SIGNED (A_SIGNED),
    .B_SIGNED (B_SIGNED),
    .MODE     (MODE)
  ) u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (p_d)
  );

  always_ff @(posedge CLK or negedge ACLR) begin
    if (!ACLR) begin
      p_q     <= '0;
      ctrl2_q <= '0;
    end else if (bus.ENA) begin
      p_q     <= p_d;
      ctrl2_q <= ctrl1_q;
    end
  end

  // Product widened to the accumulator; a signed operand makes it signed.
  always_comb begin
    p_sx  = {(P_SIGNED ? p_q[PW-1] : 1'b0), p_q};
    p_ext = ACC_WIDTH'(p_sx);
  end

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, p_ext};
    add_res = sum[ACC_WIDTH-1:0];
    if (P_SIGNED) begin
      add_ovf = (acc_q[MSB] == p_ext[MSB]) && (sum[MSB] != acc_q[MSB]);
    end else begin
      add_ovf = sum[ACC_WIDTH];
    end
`ifdef MISTRAL_DSP_ACC_SAT_EN
    // Overflow direction follows the addend's sign.
    if (add_ovf) begin
      if (P_SIGNED) begin
        add_res = p_ext[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        add_res = '1;
      end
    end
`endif
  end

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (ctrl2_q.valid) begin
      if (ctrl2_q.load || !ctrl2_q.acc) begin
        acc_d = p_ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = add_res;
        ovf_d = ovf_q | add_ovf;
      end
    end
  end

  always_ff @(posedge CLK or negedge ACLR) begin
    if (!ACLR) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.ENA) begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= ctrl2_q.valid;
    end
  end

  assign bus.Y         = acc_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_mistral_dsp_mac.sv
// Bench for mistral_dsp_mac: four configurations share clock, reset and ENA.
// Expectations for MISTRAL_DSP_ACC_SAT_EN builds follow the same macro.
module tb_mistral_dsp_mac;

  localparam logic signed [127:0] ONE = 128'sd1;

  // inst0: 8x8 unsigned acc64, inst1: 27x27 signed acc64,
  // inst2: 8x8 unsigned acc16, inst3: 12 signed x 10 unsigned acc22 (MUL18)
  int p_aw   [4] = '{8, 27, 8, 12};
  int p_bw   [4] = '{8, 27, 8, 10};
  bit p_as   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  bit p_bs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int p_accw [4] = '{64, 64, 16, 22};

  logic clk = 1'b0;
  logic aclr;
  logic ena;
  logic        in_v  [4];
  logic [26:0] in_a  [4];
  logic [26:0] in_b  [4];
  logic        in_ld [4];
  logic        in_ac [4];

  logic [64:0] exp_q [4][$];
  logic [63:0] m_acc [4];
  bit          m_ovf [4];
  int          out_cnt [4];
  int          last_out_cyc [4];
  int          cyc;
  logic        ena_edge;
  int          n_chk;
  int          n_pass;

  always #5 clk = ~clk;

  mistral_dsp_mac_if #(.A_WIDTH(8),  .B_WIDTH(8),  .ACC_WIDTH(64)) if0 ();
  mistral_dsp_mac_if #(.A_WIDTH(27), .B_WIDTH(27), .ACC_WIDTH(64)) if1 ();
  mistral_dsp_mac_if #(.A_WIDTH(8),  .B_WIDTH(8),  .ACC_WIDTH(16)) if2 ();
  mistral_dsp_mac_if #(.A_WIDTH(12), .B_WIDTH(10), .ACC_WIDTH(22)) if3 ();

  assign if0.ENA = ena; assign if0.IN_VALID = in_v[0]; assign if0.LOAD = in_ld[0]; assign if0.ACC = in_ac[0];
  assign if0.A = in_a[0][7:0];  assign if0.B = in_b[0][7:0];
  assign if1.ENA = ena; assign if1.IN_VALID = in_v[1]; assign if1.LOAD = in_ld[1]; assign if1.ACC = in_ac[1];
  assign if1.A = in_a[1];       assign if1.B = in_b[1];
  assign if2.ENA = ena; assign if2.IN_VALID = in_v[2]; assign if2.LOAD = in_ld[2]; assign if2.ACC = in_ac[2];
  assign if2.A = in_a[2][7:0];  assign if2.B = in_b[2][7:0];
  assign if3.ENA = ena; assign if3.IN_VALID = in_v[3]; assign if3.LOAD = in_ld[3]; assign if3.ACC = in_ac[3];
  assign if3.A = in_a[3][11:0]; assign if3.B = in_b[3][9:0];

  mistral_dsp_mac #(.A_WIDTH(8), .B_WIDTH(8), .A_SIGNED(1'b0), .B_SIGNED(1'b0), .ACC_WIDTH(64))
    u0 (.CLK(clk), .ACLR(aclr), .bus(if0));
  mistral_dsp_mac #(.A_WIDTH(27), .B_WIDTH(27), .A_SIGNED(1'b1), .B_SIGNED(1'b1), .ACC_WIDTH(64))
    u1 (.CLK(clk), .ACLR(aclr), .bus(if1));
  mistral_dsp_mac #(.A_WIDTH(8), .B_WIDTH(8), .A_SIGNED(1'b0), .B_SIGNED(1'b0), .ACC_WIDTH(16))
    u2 (.CLK(clk), .ACLR(aclr), .bus(if2));
  mistral_dsp_mac #(.A_WIDTH(12), .B_WIDTH(10), .A_SIGNED(1'b1), .B_SIGNED(1'b0), .ACC_WIDTH(22))
    u3 (.CLK(clk), .ACLR(aclr), .bus(if3));

  // {OUT_VALID, OVF, Y zero-extended to 64}
  function automatic logic [65:0] obs(input int i);
    case (i)
      0:       return {if0.OUT_VALID, if0.OVF, 64'(if0.Y)};
      1:       return {if1.OUT_VALID, if1.OVF, 64'(if1.Y)};
      2:       return {if2.OUT_VALID, if2.OVF, 64'(if2.Y)};
      default: return {if3.OUT_VALID, if3.OVF, 64'(if3.Y)};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic signed [127:0] ext(input logic [26:0] v, input int w, input bit s);
    logic signed [127:0] r;
    r = '0;
    for (int k = 0; k < w; k++) r[k] = v[k];
    if (s && v[w-1]) r = r - (ONE <<< w);
    return r;
  endfunction

  // Reference: exact integer arithmetic, then range-check and reduce to ACC bits.
  task automatic model_push(input int i);
    logic signed [127:0] av, bv, pv, accv, sum, res, lim_hi, lim_lo, modv;
    logic [63:0] y;
    bit sgn;
    modv = ONE <<< p_accw[i];
    sgn  = p_as[i] || p_bs[i];
    av   = ext(in_a[i], p_aw[i], p_as[i]);
    bv   = ext(in_b[i], p_bw[i], p_bs[i]);
    pv   = av * bv;
    if (in_ld[i] || !in_ac[i]) begin
      res      = pv;
      m_ovf[i] = 1'b0;
    end else begin
      accv = 128'(m_acc[i]);
      if (sgn) begin
        if (accv >= modv / 2) accv = accv - modv;
        lim_hi = modv / 2 - 1;
        lim_lo = -(modv / 2);
      end else begin
        lim_hi = modv - 1;
        lim_lo = 0;
      end
      sum = accv + pv;
      res = sum;
`ifdef MISTRAL_DSP_ACC_SAT_EN
      if (sum > lim_hi)      res = lim_hi;
      else if (sum < lim_lo) res = lim_lo;
`endif
      if ((sum > lim_hi) || (sum < lim_lo)) m_ovf[i] = 1'b1;
    end
    y = '0;
    for (int k = 0; k < p_accw[i]; k++) y[k] = res[k];
    m_acc[i] = y;
    exp_q[i].push_back({m_ovf[i], y});
  endtask

  task automatic set_in(input int i, input logic [26:0] a, input logic [26:0] b,
                        input bit ld, input bit ac);
    in_v[i]  = 1'b1;
    in_a[i]  = a;
    in_b[i]  = b;
    in_ld[i] = ld;
    in_ac[i] = ac;
  endtask

  task automatic check_outputs();
    logic [65:0] o;
    logic [64:0] e;
    for (int i = 0; i < 4; i++) begin
      o = obs(i);
      if (ena_edge && o[65]) begin
        out_cnt[i]++;
        last_out_cyc[i] = cyc;
        n_chk++;
        assert (exp_q[i].size() > 0) n_pass++;
        else $error("FAIL unexpected_out inst%0d got=%h expected none", i, o[64:0]);
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          chk($sformatf("sb_inst%0d", i), {1'b0, o[64:0]}, {1'b0, e});
        end
      end
    end
  endtask

  // One clock: record accepted samples, clock, then compare at the falling edge.
  task automatic step();
    for (int i = 0; i < 4; i++) begin
      if (ena && in_v[i]) model_push(i);
    end
    ena_edge = ena;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
    for (int i = 0; i < 4; i++) in_v[i] = 1'b0;
  endtask

  initial begin
    logic [65:0] o;
    int base;
    int drv_cyc;
    n_chk = 0; n_pass = 0; cyc = 0; ena_edge = 1'b0;
    aclr = 1'b0; ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_v[i] = 1'b0; in_a[i] = '0; in_b[i] = '0; in_ld[i] = 1'b0; in_ac[i] = 1'b0;
      m_acc[i] = '0; m_ovf[i] = 1'b0; out_cnt[i] = 0; last_out_cyc[i] = -1;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("reset_inst%0d", i), obs(i), 66'd0);
    aclr = 1'b1;
    step(); step();

    // 8x8 unsigned full-scale load
    set_in(0, 27'd255, 27'd255, 1'b1, 1'b0); step(); step(); step();
    chk("u8_load", obs(0), {2'b10, 64'd65025});

    // 27x27 signed: most negative B times -1, then a negative accumulate
    set_in(1, 27'h7FFFFFF, 27'h4000000, 1'b1, 1'b0); step();
    set_in(1, 27'd3, 27'h7FFFFFB, 1'b0, 1'b1); step(); step();
    chk("s27_load", obs(1), {2'b10, 64'd67108864});
    step();
    chk("s27_acc", obs(1), {2'b10, 64'd67108849});

    // 16-bit unsigned accumulator overflow, then reload clears OVF
    set_in(2, 27'd255, 27'd255, 1'b1, 1'b0); step();
    set_in(2, 27'd255, 27'd255, 1'b0, 1'b1); step();
    set_in(2, 27'd1, 27'd1, 1'b1, 1'b0); step();
    chk("a16_load", obs(2), {2'b10, 64'd65025});
    step();
`ifdef MISTRAL_DSP_ACC_SAT_EN
    chk("a16_ovf", obs(2), {2'b11, 64'd65535});
`else
    chk("a16_ovf", obs(2), {2'b11, 64'd64514});
`endif
    step();
    chk("a16_reload", obs(2), {2'b10, 64'd1});

    // Mixed signedness, 22-bit accumulator: negative then positive overflow
    set_in(3, 27'h800, 27'd1023, 1'b1, 1'b0); step();
    set_in(3, 27'h800, 27'd1023, 1'b0, 1'b1); step();
    set_in(3, 27'd1, 27'd1, 1'b0, 1'b1); step();
    step();
`ifdef MISTRAL_DSP_ACC_SAT_EN
    chk("m22_neg_ovf", obs(3), {2'b11, 64'h200000});
`else
    chk("m22_neg_ovf", obs(3), {2'b11, 64'd4096});
`endif
    set_in(3, 27'h7FF, 27'd1023, 1'b1, 1'b0); step();
    set_in(3, 27'h7FF, 27'd1023, 1'b0, 1'b1); step();
    set_in(3, 27'h7FF, 27'd1023, 1'b0, 1'b1); step();
    repeat (3) step();

    // ENA low for two cycles mid-stream; junk presented while frozen
    base = out_cnt[0];
    set_in(0, 27'd10, 27'd20, 1'b1, 1'b0); step();
    set_in(0, 27'd3, 27'd4, 1'b0, 1'b1); step();
    ena = 1'b0;
    repeat (2) begin
      set_in(0, 27'd99, 27'd99, 1'b1, 1'b0); step();
    end
    ena = 1'b1;
    set_in(0, 27'd5, 27'd6, 1'b0, 1'b1); step();
    set_in(0, 27'd7, 27'd8, 1'b0, 1'b1); step();
    repeat (4) step();
    chk("ena_pulses", 66'(out_cnt[0] - base), 66'd4);
    o = obs(0);
    chk("ena_sum", {2'b00, o[63:0]}, 66'd298);

    // Random traffic with ENA dropouts on the signed and mixed instances
    for (int n = 0; n < 24; n++) begin
      ena = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) != 0)
        set_in(3, 27'($urandom_range(0, 4095)), 27'($urandom_range(0, 1023)),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 2) != 0)
        set_in(1, 27'($urandom()), 27'($urandom()),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1));
      step();
    end
    ena = 1'b1;
    repeat (4) step();

    // Asynchronous clear with two samples in flight
    set_in(0, 27'd9, 27'd9, 1'b1, 1'b0); step();
    set_in(0, 27'd2, 27'd2, 1'b0, 1'b1); step();
    aclr = 1'b0;
    #1;
    chk("aclr_imm", obs(0), 66'd0);
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      m_acc[i] = '0;
      m_ovf[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    aclr = 1'b1;
    repeat (4) step();
    chk("aclr_no_stale", obs(0), 66'd0);
    drv_cyc = cyc;
    set_in(0, 27'd7, 27'd7, 1'b1, 1'b0); step(); step(); step();
    chk("aclr_latency", 66'(last_out_cyc[0]), 66'(drv_cyc + 3));
    chk("aclr_first", obs(0), {2'b10, 64'd49});

    repeat (4) step();
    for (int i = 0; i < 4; i++) chk($sformatf("drain_inst%0d", i), 66'(exp_q[i].size()), 66'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
